vermibus_interconnect: RTL and testbench
========================================

# vermibus_interconnect

Parametrised single-master, N-device bus interconnect for the Vermicel SoC, sitting between the CPU bus and its memory-mapped devices. It decodes the CPU request onto one of `NUM_DEVICES` device ports by address region, returns data/ready from the selected device, and aggregates device interrupts through an enable mask. It also answers unmapped accesses with an error response, aborts device accesses that exceed a timeout, and exposes its own control/status registers.

## Interface
- `NUM_DEVICES`, 4, number of device ports, 1..8
- `DEV_REGION`, {8'h00, 8'h80, 8'h81, 8'h82}, packed array of 8-bit region IDs compared against `address[31:24]`; entry i selects device i
- `CTRL_REGION`, 8'hFF, region ID of the internal register block
- `TIMEOUT_CYCLES`, 255, maximum wait cycles before abort; 0 disables timeout; counter width = $clog2(TIMEOUT_CYCLES+1)
- `clk` in 1 system clock, all logic on rising edge
- `reset` in 1 asynchronous, active-low reset
- `m_valid` in 1 CPU request valid
- `m_address` in 32 CPU byte address
- `m_wstrobe` in 4 byte write enables; 0 = read
- `m_wdata` in 32 write data
- `m_rdata` out 32 read data to CPU
- `m_ready` out 1 transfer complete
- `m_irq` out 1 aggregated interrupt
- `s_valid` out NUM_DEVICES per-device request valid
- `s_address` out 32 broadcast address
- `s_wstrobe` out 4 broadcast strobes
- `s_wdata` out 32 broadcast write data
- `s_rdata` in NUM_DEVICES×32 per-device read data
- `s_ready` in NUM_DEVICES per-device ready
- `s_irq` in NUM_DEVICES per-device level interrupt

## Operation
- Handshake: transfer completes in the cycle with `m_valid && m_ready`; CPU holds request fields stable until then.
- Decode: region = `m_address[31:24]`; lowest-index matching `DEV_REGION` entry wins; `CTRL_REGION` → internal; no match → unmapped. `CTRL_REGION` takes priority over device entries.
- Address/strobe/wdata broadcast unmodified to all devices; only selected `s_valid` asserted.
- FSM states IDLE, WAIT, LOCAL, ABORT:
  - IDLE: `m_valid` to device i → `s_valid[i]`=1, `m_ready`/`m_rdata` = `s_ready[i]`/`s_rdata[i]` combinationally; no ready → WAIT (count=1). Internal or unmapped → LOCAL.
  - WAIT: forward as in IDLE; `s_ready[i]` → IDLE; else count==`TIMEOUT_CYCLES` (nonzero) → ABORT; else count+1.
  - LOCAL: `m_ready`=1; internal: read data / write commit; unmapped: `m_rdata`=0, ERR_STATUS[0] set, ERR_ADDR captured; → IDLE.
  - ABORT: `s_valid` all 0, `m_ready`=1, `m_rdata`=0, ERR_STATUS[1] set, ERR_ADDR captured; → IDLE.
- Internal registers (offset `m_address[3:2]`):
  - 0x0 IRQ_PENDING, RO: raw `s_irq`, upper bits 0
  - 0x4 IRQ_ENABLE, RW, byte strobes honoured, bits ≥ NUM_DEVICES read 0
  - 0x8 ERR_STATUS, W1C on byte 0; bit0 unmapped, bit1 timeout, sticky
  - 0xC ERR_ADDR, RO: address of most recent error
- `m_irq` = |(`s_irq` & IRQ_ENABLE), combinational.
- Outside a transfer: `m_ready`=0, `m_rdata`=0, `s_valid`=0.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, IRQ_ENABLE 0, ERR_STATUS 0, ERR_ADDR 0; so `m_ready`=0, `m_irq`=0, `s_valid`=0.
- Device access: zero added latency; zero-wait device completes in cycle 0.
- Internal/unmapped: one wait state; `m_ready` in cycle 1.
- Timeout: request at cycle 0, no device ready through cycle T → `m_ready` in cycle T+1. A device ready in cycle T is accepted normally.
- Back-to-back: new request accepted in IDLE the cycle after completion.
- Reset mid-transfer: aborts silently; no error recorded.
- New error overwrites ERR_ADDR; status bits OR in.

## Test plan
- Read 0x8000_0004, timer model ready after 2 cycles with rdata 0x1234 → `s_valid`=4'b0010, `m_ready` in cycle 2, `m_rdata`=0x1234, no error.
- Read 0x4000_0000 → `m_ready` in cycle 1, `m_rdata`=0, ERR_STATUS=0x1, ERR_ADDR=0x4000_0000; write 0x1 to 0xFF00_0008 → ERR_STATUS=0.
- `TIMEOUT_CYCLES`=4, device 2 never ready → `m_ready` in cycle 5, `s_valid[2]` low in cycle 5, ERR_STATUS=0x2; device ready in cycle 4 → normal completion.
- Write 0x5 to 0xFF00_0004, `s_irq`=4'b0110 → `m_irq`=1; `s_irq`=4'b1010 → `m_irq`=0; read 0xFF00_0000 → 0x0000_000A.
- Assert `reset` low during WAIT → `m_ready`, `s_valid`, `m_irq` 0 immediately; IRQ_ENABLE 0, ERR_STATUS 0 after release.
- Overlapping `DEV_REGION` entries 0 and 1 both 8'h00 → only `s_valid[0]` asserted.

Source files
------------

// File: rtl/vermibus_if.sv
// Bus bundle between the CPU, the interconnect and its device ports.
// The slave modport is the interconnect's view; master is the CPU/device side.
interface vermibus_if #(
  parameter int NUM_DEVICES = 4
);
  logic                         m_valid;
  logic [31:0]                  m_address;
  logic [3:0]                   m_wstrobe;
  logic [31:0]                  m_wdata;
  logic [31:0]                  m_rdata;
  logic                         m_ready;
  logic                         m_irq;
  logic [NUM_DEVICES-1:0]       s_valid;
  logic [31:0]                  s_address;
  logic [3:0]                   s_wstrobe;
  logic [31:0]                  s_wdata;
  logic [NUM_DEVICES-1:0][31:0] s_rdata;
  logic [NUM_DEVICES-1:0]       s_ready;
  logic [NUM_DEVICES-1:0]       s_irq;

  modport slave (
    input  m_valid, m_address, m_wstrobe, m_wdata,
    output m_rdata, m_ready, m_irq,
    output s_valid, s_address, s_wstrobe, s_wdata,
    input  s_rdata, s_ready, s_irq
  );

  modport master (
    output m_valid, m_address, m_wstrobe, m_wdata,
    input  m_rdata, m_ready, m_irq,
    input  s_valid, s_address, s_wstrobe, s_wdata,
    output s_rdata, s_ready, s_irq
  );
endinterface

// File: rtl/vermibus_interconnect.sv
// Single-master, N-device region decoder with timeout abort, error capture and IRQ masking.
// Device accesses add no latency; internal/unmapped accesses take one wait state.
module vermibus_interconnect #(
  parameter int                          NUM_DEVICES    = 4,
  // Entry i (index 0 = least significant byte) is the region of device i.
  parameter logic [NUM_DEVICES-1:0][7:0] DEV_REGION     = {8'h82, 8'h81, 8'h80, 8'h00},
  parameter logic [7:0]                  CTRL_REGION    = 8'hFF,
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       reset,
  vermibus_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, LOCAL, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DEVICES-1:0] irq_en_q;
  logic [1:0]             err_q;
  logic [31:0]            err_addr_q;

  logic [7:0]    region;
  logic          is_ctrl;
  logic          dev_hit;
  logic [DW-1:0] dev_idx;
  logic [31:0]   reg_rdata;

  assign region        = bus.m_address[31:24];
  assign bus.s_address = bus.m_address;
  assign bus.s_wstrobe = bus.m_wstrobe;
  assign bus.s_wdata   = bus.m_wdata;
  assign bus.m_irq     = |(bus.s_irq & irq_en_q);

  // Scan downwards so the lowest matching entry wins; the control region overrides all.
  always_comb begin
    is_ctrl = (region == CTRL_REGION);
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (region == DEV_REGION[i]) begin
        dev_hit = 1'b1;
        dev_idx = DW'(i);
      end
    end
    if (is_ctrl) dev_hit = 1'b0;
  end

  always_comb begin
    reg_rdata = '0;
    case (bus.m_address[3:2])
      2'd0:    reg_rdata = 32'(bus.s_irq);
      2'd1:    reg_rdata = 32'(irq_en_q);
      2'd2:    reg_rdata = {30'b0, err_q};
      default: reg_rdata = err_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus.s_valid = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          if (dev_hit) begin
            bus.s_valid[dev_idx] = 1'b1;
            bus.m_ready          = bus.s_ready[dev_idx];
            bus.m_rdata          = bus.s_rdata[dev_idx];
            if (!bus.s_ready[dev_idx]) begin
              state_d = WAIT;
              cnt_d   = CW'(1);
            end
          end else begin
            state_d = LOCAL;
          end
        end
      end
      WAIT: begin
        bus.s_valid[dev_idx] = 1'b1;
        bus.m_ready          = bus.s_ready[dev_idx];
        bus.m_rdata          = bus.s_rdata[dev_idx];
        if (bus.s_ready[dev_idx]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES)) state_d = ABORT;
          else                              cnt_d   = cnt_q + CW'(1);
        end
      end
      LOCAL: begin
        bus.m_ready = 1'b1;
        if (is_ctrl && bus.m_wstrobe == 4'b0) bus.m_rdata = reg_rdata;
        state_d = IDLE;
      end
      default: begin
        bus.m_ready = 1'b1;
        state_d     = IDLE;
        cnt_d       = '0;
      end
    endcase
    // While reset is held the CPU may still present a request; keep everything quiet.
    if (!reset) begin
      bus.s_valid = '0;
      bus.m_ready = 1'b0;
      bus.m_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q   <= '0;
      err_q      <= '0;
      err_addr_q <= '0;
    end else if (state_q == LOCAL) begin
      if (is_ctrl) begin
        if (bus.m_wstrobe[0]) begin
          case (bus.m_address[3:2])
            2'd1:    irq_en_q <= bus.m_wdata[NUM_DEVICES-1:0];
            2'd2:    err_q    <= err_q & ~bus.m_wdata[1:0];
            default: ;
          endcase
        end
      end else begin
        err_q[0]   <= 1'b1;
        err_addr_q <= bus.m_address;
      end
    end else if (state_q == ABORT) begin
      err_q[1]   <= 1'b1;
      err_addr_q <= bus.m_address;
    end
  end
endmodule

// File: tb/tb_vermibus_interconnect.sv
// Table-driven bench for vermibus_interconnect with a response scoreboard.
// Instance a: default map, long timeout. Instance b: timeout 4, devices 0/1 overlap.
module tb_vermibus_interconnect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bit              sel = 1'b0;
  logic            m_valid = 1'b0;
  logic [31:0]     m_address = '0;
  logic [3:0]      m_wstrobe = '0;
  logic [31:0]     m_wdata = '0;
  logic [3:0][31:0] s_rdata = '0;
  logic [3:0]      s_ready = '0;
  logic [3:0]      s_irq = '0;

  vermibus_if #(.NUM_DEVICES(4)) b0 ();
  vermibus_if #(.NUM_DEVICES(4)) b1 ();

  assign b0.m_valid = m_valid && !sel;
  assign b1.m_valid = m_valid && sel;
  assign b0.m_address = m_address;  assign b1.m_address = m_address;
  assign b0.m_wstrobe = m_wstrobe;  assign b1.m_wstrobe = m_wstrobe;
  assign b0.m_wdata   = m_wdata;    assign b1.m_wdata   = m_wdata;
  assign b0.s_rdata   = s_rdata;    assign b1.s_rdata   = s_rdata;
  assign b0.s_ready   = s_ready;    assign b1.s_ready   = s_ready;
  assign b0.s_irq     = s_irq;      assign b1.s_irq     = s_irq;

  vermibus_interconnect dut_a (.clk(clk), .reset(reset), .bus(b0));
  vermibus_interconnect #(
    .TIMEOUT_CYCLES(4),
    .DEV_REGION({8'h82, 8'h81, 8'h00, 8'h00})
  ) dut_b (.clk(clk), .reset(reset), .bus(b1));

  logic        o_ready, o_irq;
  logic [31:0] o_rdata, o_saddr;
  logic [3:0]  o_sval;
  assign o_ready = sel ? b1.m_ready   : b0.m_ready;
  assign o_irq   = sel ? b1.m_irq     : b0.m_irq;
  assign o_rdata = sel ? b1.m_rdata   : b0.m_rdata;
  assign o_saddr = sel ? b1.s_address : b0.s_address;
  assign o_sval  = sel ? b1.s_valid   : b0.s_valid;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    int          dev;       // target device of the model, -1 for local/unmapped
    int          rdy_at;    // cycle the target device raises ready
    logic [31:0] dev_rdata;
    logic [3:0]  exp_sval;
    logic [31:0] exp_rdata;
    bit          chk_rd;
    int          exp_lat;
    bit          abort;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] exp);
    vec_t v = '{addr:a, wstrobe:4'b0, wdata:'0, dev:-1, rdy_at:0, dev_rdata:'0,
                exp_sval:4'b0, exp_rdata:exp, chk_rd:1'b1, exp_lat:1, abort:1'b0};
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    vec_t v = rd(a, '0);
    v.wstrobe = st;
    v.wdata   = d;
    v.chk_rd  = 1'b0;
    return v;
  endfunction

  function automatic vec_t dv(input logic [31:0] a, input logic [3:0] st, input int dev,
                              input int rdy_at, input logic [31:0] rdat, input int lat,
                              input bit abort);
    vec_t v = rd(a, abort ? 32'h0 : rdat);
    v.wstrobe   = st;
    v.wdata     = 32'h5A5A_0000 | a[15:0];
    v.dev       = dev;
    v.rdy_at    = rdy_at;
    v.dev_rdata = rdat;
    v.exp_sval  = 4'b1 << dev;
    v.chk_rd    = (st == 4'b0);
    v.exp_lat   = lat;
    v.abort     = abort;
    return v;
  endfunction

  task automatic run(input vec_t v);
    exp_t e;
    int   k;
    bit   done;
    e.rdata = v.exp_rdata;
    e.lat   = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    m_valid = 1'b1; m_address = v.addr; m_wstrobe = v.wstrobe; m_wdata = v.wdata;
    for (int i = 0; i < 4; i++) s_rdata[i] = (i == v.dev) ? v.dev_rdata : (32'hBAD0_0000 | i);
    k = 0;
    done = 1'b0;
    while (!done) begin
      s_ready = '0;
      if (v.dev >= 0 && k >= v.rdy_at) s_ready[v.dev] = 1'b1;
      #1;
      if (k == 0) begin
        check("s_valid_first", 32'(o_sval), 32'(v.exp_sval));
        check("s_address", o_saddr, v.addr);
      end
      if (o_ready) begin
        e = sb.pop_front();
        check("latency", 32'(k), 32'(e.lat));
        if (v.chk_rd) check("m_rdata", o_rdata, e.rdata);
        check("s_valid_done", 32'(o_sval), v.abort ? 32'h0 : 32'(v.exp_sval));
        done = 1'b1;
      end else if (k >= 300) begin
        e = sb.pop_front();
        check("ready_budget", 32'(k), 32'(e.lat));
        done = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  initial begin
    // Instance a: regions 0:00 1:80 2:81 3:82.
    tbl.push_back(dv(32'h8000_0004, 4'b0, 1, 2, 32'h0000_1234, 2, 1'b0));
    tbl.push_back(rd(32'hFF00_0008, 32'h0));
    tbl.push_back(rd(32'h4000_0000, 32'h0));
    tbl.push_back(rd(32'hFF00_0008, 32'h1));
    tbl.push_back(rd(32'hFF00_000C, 32'h4000_0000));
    tbl.push_back(wr(32'hFF00_0008, 4'b0001, 32'h1));
    tbl.push_back(rd(32'hFF00_0008, 32'h0));
    tbl.push_back(dv(32'h0000_0010, 4'b0, 0, 0, 32'hAAAA_5555, 0, 1'b0));
    tbl.push_back(dv(32'h8200_0000, 4'b1111, 3, 1, 32'h0, 1, 1'b0));
    tbl.push_back(dv(32'h8100_0020, 4'b0, 2, 3, 32'h7777_0002, 3, 1'b0));
    tbl.push_back(wr(32'hFF00_0004, 4'b0001, 32'hFF));
    tbl.push_back(rd(32'hFF00_0004, 32'hF));
    tbl.push_back(wr(32'hFF00_0004, 4'b0001, 32'h5));
    tbl.push_back(wr(32'hFF00_0004, 4'b0010, 32'hFFFF_FFFF));
    tbl.push_back(rd(32'hFF00_0004, 32'h5));
    tbl.push_back(rd(32'hFF00_0000, 32'h0));

    #2;
    check("rst_ready_a", 32'(b0.m_ready), 32'h0);
    check("rst_sval_a", 32'(b0.s_valid), 32'h0);
    check("rst_irq_a", 32'(b0.m_irq), 32'h0);
    check("rst_ready_b", 32'(b1.m_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
    idle();

    // Interrupt masking with IRQ_ENABLE = 0x5.
    s_irq = 4'b0110; #1;
    check("irq_0110", 32'(o_irq), 32'h1);
    s_irq = 4'b1010; #1;
    check("irq_1010", 32'(o_irq), 32'h0);
    run(rd(32'hFF00_0000, 32'h0000_000A));
    run(rd(32'h1200_0000, 32'h0));
    idle();

    // Reset in the middle of a waiting device access.
    s_irq = 4'b0001; #1;
    check("irq_pre_reset", 32'(o_irq), 32'h1);
    @(negedge clk);
    m_valid = 1'b1; m_address = 32'h8000_0000; m_wstrobe = 4'b0; s_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    check("wait_ready", 32'(o_ready), 32'h0);
    check("wait_sval", 32'(o_sval), 32'h2);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(o_ready), 32'h0);
    check("rst_mid_sval", 32'(o_sval), 32'h0);
    check("rst_mid_irq", 32'(o_irq), 32'h0);
    m_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run(rd(32'hFF00_0004, 32'h0));
    run(rd(32'hFF00_0008, 32'h0));
    run(rd(32'hFF00_000C, 32'h0));
    idle();

    // Instance b: timeout 4, overlapping regions.
    sel = 1'b1;
    s_irq = '0;
    run(dv(32'h8100_0000, 4'b0, 2, 1000, 32'hDEAD_BEEF, 5, 1'b1));
    run(rd(32'hFF00_0008, 32'h2));
    run(rd(32'hFF00_000C, 32'h8100_0000));
    run(dv(32'h8100_0000, 4'b0, 2, 4, 32'h0000_CAFE, 4, 1'b0));
    run(rd(32'hFF00_0008, 32'h2));
    run(dv(32'h0000_0004, 4'b0, 0, 1, 32'h0BAD_F00D, 1, 1'b0));
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
